// File: rtl/spiking_lif_neuron.sv
// Leaky integrate-and-fire neuron: weighted spike integration, saturating potential, threshold fire, refractory hold.
// One-cycle latency from an en step to out/potential; no backpressure. Optional spike counter under SPIKE_COUNTER_EN.
module spiking_lif_neuron #(
    parameter int N_INPUTS       = 2,
    parameter int INT_WIDTH      = 4,
    parameter int POT_WIDTH      = 8,
    parameter int LEAK_SHIFT     = 0,
    parameter int REFRACT_CYCLES = 2,
    localparam int AW            = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [N_INPUTS-1:0]         in,
    input  logic                        w_we,
    input  logic [AW-1:0]               w_addr,
    input  logic signed [INT_WIDTH-1:0] w_data,
    input  logic signed [POT_WIDTH-1:0] threshold,
    output logic                        out,
    output logic signed [POT_WIDTH-1:0] potential,
    output logic                        refractory
`ifdef SPIKE_COUNTER_EN
    ,
    output logic [15:0]                 spike_count
`endif
);

    localparam int SW = POT_WIDTH + $clog2(N_INPUTS) + 1;
    localparam int CW = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;

    // Saturation bounds of the potential, expressed at the wide sum width.
    localparam logic signed [SW-1:0] C_MAX = {{(SW-POT_WIDTH+1){1'b0}}, {(POT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] C_MIN = {{(SW-POT_WIDTH+1){1'b1}}, {(POT_WIDTH-1){1'b0}}};

    typedef enum logic {
        ST_INTEGRATE  = 1'b0,
        ST_REFRACTORY = 1'b1
    } state_t;

    state_t                        r_state;
    logic [CW-1:0]                 r_cnt;
    logic                          r_out;
    logic                          r_refractory;
    logic signed [POT_WIDTH-1:0]   r_pot;
    logic signed [INT_WIDTH-1:0]   r_weight [N_INPUTS];

    logic                          w_addr_ok;
    logic signed [POT_WIDTH-1:0]   w_leaked;
    logic signed [SW-1:0]          w_sum;
    logic signed [POT_WIDTH-1:0]   w_sat;
    logic                          w_fire;

    assign w_addr_ok = ({1'b0, w_addr} < (AW+1)'(N_INPUTS));

    always_comb begin
        w_leaked = r_pot;
        if (LEAK_SHIFT > 0) begin
            w_leaked = r_pot - (r_pot >>> LEAK_SHIFT);
        end

        w_sum = {{(SW-POT_WIDTH){w_leaked[POT_WIDTH-1]}}, w_leaked};
        for (int i = 0; i < N_INPUTS; i++) begin
            if (in[i]) begin
                w_sum = w_sum + $signed({{(SW-INT_WIDTH){r_weight[i][INT_WIDTH-1]}}, r_weight[i]});
            end
        end

        if (w_sum > C_MAX) begin
            w_sat = {1'b0, {(POT_WIDTH-1){1'b1}}};
        end else if (w_sum < C_MIN) begin
            w_sat = {1'b1, {(POT_WIDTH-1){1'b0}}};
        end else begin
            w_sat = w_sum[POT_WIDTH-1:0];
        end

        w_fire = (w_sat >= threshold);
    end

    // Weight writes land at the edge, so an en step in the same cycle sees the old weight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                r_weight[i] <= '0;
            end
        end else if (w_we && w_addr_ok) begin
            r_weight[w_addr] <= w_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_INTEGRATE;
            r_cnt        <= '0;
            r_out        <= 1'b0;
            r_refractory <= 1'b0;
            r_pot        <= '0;
        end else begin
            r_out <= 1'b0;
            if (en) begin
                case (r_state)
                    ST_INTEGRATE: begin
                        if (w_fire) begin
                            r_out <= 1'b1;
                            r_pot <= '0;
                            if (REFRACT_CYCLES > 0) begin
                                r_cnt        <= CW'(REFRACT_CYCLES);
                                r_state      <= ST_REFRACTORY;
                                r_refractory <= 1'b1;
                            end
                        end else begin
                            r_pot <= w_sat;
                        end
                    end
                    ST_REFRACTORY: begin
                        r_pot <= '0;
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_state      <= ST_INTEGRATE;
                            r_refractory <= 1'b0;
                        end
                    end
                    default: begin
                        r_state      <= ST_INTEGRATE;
                        r_refractory <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out        = r_out;
    assign potential  = r_pot;
    assign refractory = r_refractory;

`ifdef SPIKE_COUNTER_EN
    logic [15:0] r_spike_cnt;
    logic        w_cnt_clr;
    logic        w_cnt_inc;

    // The address just past the last weight doubles as the counter clear strobe.
    assign w_cnt_clr = w_we && ({1'b0, w_addr} == (AW+1)'(N_INPUTS));
    assign w_cnt_inc = en && (r_state == ST_INTEGRATE) && w_fire && (r_spike_cnt != 16'hFFFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_spike_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_spike_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_spike_cnt <= r_spike_cnt + 16'd1;
        end
    end

    assign spike_count = r_spike_cnt;
`endif

endmodule

// File: tb/tb_spiking_lif_neuron.sv
// Self-checking bench for spiking_lif_neuron: scoreboard of expected out/potential/refractory per clocked step.
module tb_spiking_lif_neuron;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              w_we;
    logic [4:0]        in_v;
    logic [2:0]        w_addr;
    logic signed [3:0] w_data;
    logic signed [7:0] thr;

    logic              a_out, a_ref, b_out, b_ref;
    logic signed [7:0] a_pot, b_pot;
`ifdef SPIKE_COUNTER_EN
    logic [15:0]       a_cnt, b_cnt;
`endif

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        string tag;
        bit    sel;
        bit    o;
        int    pot;
        bit    r;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    spiking_lif_neuron #(
        .N_INPUTS(5), .INT_WIDTH(4), .POT_WIDTH(8), .LEAK_SHIFT(0), .REFRACT_CYCLES(2)
    ) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .in(in_v),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .threshold(thr),
        .out(a_out), .potential(a_pot), .refractory(a_ref)
`ifdef SPIKE_COUNTER_EN
        , .spike_count(a_cnt)
`endif
    );

    spiking_lif_neuron #(
        .N_INPUTS(2), .INT_WIDTH(4), .POT_WIDTH(8), .LEAK_SHIFT(2), .REFRACT_CYCLES(2)
    ) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .in(in_v[1:0]),
        .w_we(w_we), .w_addr(w_addr[0:0]), .w_data(w_data), .threshold(thr),
        .out(b_out), .potential(b_pot), .refractory(b_ref)
`ifdef SPIKE_COUNTER_EN
        , .spike_count(b_cnt)
`endif
    );

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle, queue its expected result, then compare once the edge has produced it.
    task automatic step(input string tag, input bit e, input logic [4:0] iv, input bit we,
                        input logic [2:0] a, input logic [3:0] d, input bit sel,
                        input bit eo, input int ep, input bit er);
        exp_t x;
        exp_t y;
        @(negedge clk);
        en = e; in_v = iv; w_we = we; w_addr = a; w_data = d;
        x.tag = tag; x.sel = sel; x.o = eo; x.pot = ep; x.r = er;
        sb.push_back(x);
        @(posedge clk);
        #1;
        en = 1'b0; w_we = 1'b0;
        y = sb.pop_front();
        chk({y.tag, ".out"}, sel ? int'(b_out) : int'(a_out), int'(y.o));
        chk({y.tag, ".pot"}, sel ? int'(b_pot) : int'(a_pot), y.pot);
        chk({y.tag, ".ref"}, sel ? int'(b_ref) : int'(a_ref), int'(y.r));
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int leak_exp[5];
        int p;
        leak_exp = '{6, 5, 4, 3, 3};

        rst = 1'b1; en = 1'b0; w_we = 1'b0; in_v = '0; w_addr = '0; w_data = '0; thr = 8'sd100;
        #3;
        chk("rst.a_out", int'(a_out), 0);
        chk("rst.a_pot", int'(a_pot), 0);
        chk("rst.a_ref", int'(a_ref), 0);
        chk("rst.b_pot", int'(b_pot), 0);
        @(negedge clk);
        rst = 1'b0;

        // Leak on the LEAK_SHIFT=2 neuron.
        step("b_wr_w0", 0, 5'b00000, 1, 3'd0, 4'sd4, 1, 0, 0, 0);
        step("b_leak_s1", 1, 5'b00001, 0, 3'd0, 4'sd0, 1, 0, 4, 0);
        step("b_leak_s2", 1, 5'b00001, 0, 3'd0, 4'sd0, 1, 0, 7, 0);
        for (int k = 0; k < 5; k++) begin
            step($sformatf("b_leak_d%0d", k), 1, 5'b00000, 0, 3'd0, 4'sd0, 1, 0, leak_exp[k], 0);
        end

        // Integrate to threshold, fire, refractory skip of two en steps.
        rst_pulse();
        thr = 8'sd10;
        step("a_wr_w0", 0, 5'b00000, 1, 3'd0, 4'sd3, 0, 0, 0, 0);
        step("a_int1", 1, 5'b00001, 0, 3'd0, 4'sd0, 0, 0, 3, 0);
        step("a_int2", 1, 5'b00001, 0, 3'd0, 4'sd0, 0, 0, 6, 0);
        step("a_int3", 1, 5'b00001, 0, 3'd0, 4'sd0, 0, 0, 9, 0);
        step("a_fire", 1, 5'b00001, 0, 3'd0, 4'sd0, 0, 1, 0, 1);
        step("a_idle", 0, 5'b00001, 0, 3'd0, 4'sd0, 0, 0, 0, 1);
        step("a_refr1", 1, 5'b00001, 0, 3'd0, 4'sd0, 0, 0, 0, 1);
        step("a_refr2", 1, 5'b00001, 0, 3'd0, 4'sd0, 0, 0, 0, 0);
        step("a_post", 1, 5'b00001, 0, 3'd0, 4'sd0, 0, 0, 3, 0);

        // Asynchronous reset with potential at 7, clears weights too.
        step("a_wr_w1", 0, 5'b00000, 1, 3'd1, 4'sd4, 0, 0, 3, 0);
        step("a_to7", 1, 5'b00010, 0, 3'd0, 4'sd0, 0, 0, 7, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.out", int'(a_out), 0);
        chk("arst.pot", int'(a_pot), 0);
        chk("arst.ref", int'(a_ref), 0);
        rst = 1'b0;
        step("arst_w_zero", 1, 5'b11111, 0, 3'd0, 4'sd0, 0, 0, 0, 0);

        // Negative saturation holds at -128.
        thr = 8'sd127;
        step("sat_wr0", 0, 5'b00000, 1, 3'd0, -4'sd8, 0, 0, 0, 0);
        step("sat_wr1", 0, 5'b00000, 1, 3'd1, -4'sd8, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            p = -16 * (k + 1);
            if (p < -128) p = -128;
            step($sformatf("sat_s%0d", k), 1, 5'b00011, 0, 3'd0, 4'sd0, 0, 0, p, 0);
        end

        // Same-cycle write uses old weight; out-of-range writes ignored; fire at equality.
        rst_pulse();
        thr = 8'sd100;
        step("wr_same", 1, 5'b00010, 1, 3'd1, 4'sd5, 0, 0, 0, 0);
        step("wr_after", 1, 5'b00010, 0, 3'd0, 4'sd0, 0, 0, 5, 0);
        step("wr_oob5", 0, 5'b00000, 1, 3'd5, 4'sd7, 0, 0, 5, 0);
        step("wr_oob6", 0, 5'b00000, 1, 3'd6, 4'sd7, 0, 0, 5, 0);
        step("wr_all", 1, 5'b11111, 0, 3'd0, 4'sd0, 0, 0, 10, 0);
        thr = 8'sd15;
        step("fire_eq", 1, 5'b00010, 0, 3'd0, 4'sd0, 0, 1, 0, 1);
`ifdef SPIKE_COUNTER_EN
        chk("cnt_one", int'(a_cnt), 1);
`endif
        thr = 8'sd5;
        step("c_refr1", 1, 5'b00000, 0, 3'd0, 4'sd0, 0, 0, 0, 1);
        step("c_refr2", 1, 5'b00000, 0, 3'd0, 4'sd0, 0, 0, 0, 0);
        step("c_fire2", 1, 5'b00010, 0, 3'd0, 4'sd0, 0, 1, 0, 1);
        step("c_refr3", 1, 5'b00000, 0, 3'd0, 4'sd0, 0, 0, 0, 1);
        step("c_refr4", 1, 5'b00000, 0, 3'd0, 4'sd0, 0, 0, 0, 0);
        step("c_fire3", 1, 5'b00010, 0, 3'd0, 4'sd0, 0, 1, 0, 1);
`ifdef SPIKE_COUNTER_EN
        chk("cnt_three", int'(a_cnt), 3);
`endif
        step("c_clr", 0, 5'b00000, 1, 3'd5, 4'sd0, 0, 0, 0, 1);
`ifdef SPIKE_COUNTER_EN
        chk("cnt_clear", int'(a_cnt), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
